// File: rtl/ti_gf4_mul_pipe.sv
// First-order threshold-implementation GF(2^4) multiplier: four shares per operand,
// N_LANES parallel nibble lanes, two elastic register stages with optional remasking.

module ti_gf4_mul_pipe #(
    parameter int N_LANES = 2,
    parameter int REFRESH = 1
) (
    input  logic                    ClkxCI,
    input  logic                    RstxBI,
    input  logic                    ClrxSI,
    input  logic                    InValidxSI,
    output logic                    InReadyxSO,
    input  logic [4*N_LANES-1:0]    XxDI0,
    input  logic [4*N_LANES-1:0]    XxDI1,
    input  logic [4*N_LANES-1:0]    XxDI2,
    input  logic [4*N_LANES-1:0]    XxDI3,
    input  logic [4*N_LANES-1:0]    YxDI0,
    input  logic [4*N_LANES-1:0]    YxDI1,
    input  logic [4*N_LANES-1:0]    YxDI2,
    input  logic [4*N_LANES-1:0]    YxDI3,
    input  logic [12*N_LANES-1:0]   RandxDI,
    output logic                    OutValidxSO,
    input  logic                    OutReadyxSI,
    output logic [4*N_LANES-1:0]    QxDO0,
    output logic [4*N_LANES-1:0]    QxDO1,
    output logic [4*N_LANES-1:0]    QxDO2,
    output logic [4*N_LANES-1:0]    QxDO3
);
    localparam int W = 4 * N_LANES;

    logic [W-1:0]          xIn      [4];
    logic [W-1:0]          yIn      [4];
    logic [3:0]            opA      [N_LANES][4];
    logic [3:0]            opB      [N_LANES][4];
    logic [3:0]            prodComb [N_LANES][4];
    logic [W-1:0]          mask     [4];
    logic [12*N_LANES-1:0] randGated;
    logic [3:0]            r0, r1, r2;

    logic [W-1:0]          prod_p1  [4];
    logic [W-1:0]          share_p2 [4];
    logic                  vld_p1, vld_p2;
    logic                  load1, load2;

    assign xIn[0] = XxDI0;
    assign xIn[1] = XxDI1;
    assign xIn[2] = XxDI2;
    assign xIn[3] = XxDI3;
    assign yIn[0] = YxDI0;
    assign yIn[1] = YxDI1;
    assign yIn[2] = YxDI2;
    assign yIn[3] = YxDI3;

    // Without refresh the randomness is forced to zero, turning stage 2 into a plain register.
    assign randGated = (REFRESH != 0) ? RandxDI : '0;

    // Each operand pair leaves out at least one share index of X and of Y.
    always_comb begin
        for (int k = 0; k < N_LANES; k++) begin
            opA[k][0] = xIn[2][4*k +: 4] ^ xIn[3][4*k +: 4];
            opB[k][0] = yIn[1][4*k +: 4] ^ yIn[2][4*k +: 4];
            opA[k][1] = xIn[0][4*k +: 4] ^ xIn[2][4*k +: 4];
            opB[k][1] = yIn[0][4*k +: 4] ^ yIn[3][4*k +: 4];
            opA[k][2] = xIn[1][4*k +: 4] ^ xIn[3][4*k +: 4];
            opB[k][2] = yIn[0][4*k +: 4] ^ yIn[3][4*k +: 4];
            opA[k][3] = xIn[0][4*k +: 4] ^ xIn[1][4*k +: 4];
            opB[k][3] = yIn[1][4*k +: 4] ^ yIn[2][4*k +: 4];
        end
    end

    for (genvar k = 0; k < N_LANES; k++) begin : gLane
        for (genvar s = 0; s < 4; s++) begin : gTerm
            gf4_mul uMul (
                .a (opA[k][s]),
                .b (opB[k][s]),
                .q (prodComb[k][s])
            );
        end
    end

    // The fourth mask closes the sum so the refreshed shares still XOR to X*Y.
    always_comb begin
        r0 = '0;
        r1 = '0;
        r2 = '0;
        for (int s = 0; s < 4; s++) mask[s] = '0;
        for (int k = 0; k < N_LANES; k++) begin
            r0 = randGated[12*k +: 4];
            r1 = randGated[12*k + 4 +: 4];
            r2 = randGated[12*k + 8 +: 4];
            mask[0][4*k +: 4] = r0;
            mask[1][4*k +: 4] = r1;
            mask[2][4*k +: 4] = r2;
            mask[3][4*k +: 4] = r0 ^ r1 ^ r2;
        end
    end

    assign load2      = vld_p1 & (~vld_p2 | OutReadyxSI);
    assign InReadyxSO = ~vld_p1 | load2;
    assign load1      = InValidxSI & InReadyxSO;

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (ClrxSI) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= load1 | (vld_p1 & ~load2);
            vld_p2 <= load2 | (vld_p2 & ~OutReadyxSI);
        end
    end

    // Stage 1: isolated non-complete product terms
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            for (int s = 0; s < 4; s++) prod_p1[s] <= '0;
        end else if (load1) begin
            for (int k = 0; k < N_LANES; k++)
                for (int s = 0; s < 4; s++)
                    prod_p1[s][4*k +: 4] <= prodComb[k][s];
        end
    end

    // Stage 2: output shares, remasked on transfer
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            for (int s = 0; s < 4; s++) share_p2[s] <= '0;
        end else if (load2) begin
            for (int s = 0; s < 4; s++) share_p2[s] <= prod_p1[s] ^ mask[s];
        end
    end

    assign OutValidxSO = vld_p2;
    assign QxDO0       = share_p2[0];
    assign QxDO1       = share_p2[1];
    assign QxDO2       = share_p2[2];
    assign QxDO3       = share_p2[3];

endmodule

// GF(2^4) multiplier in polynomial basis, field polynomial x^4 + x + 1.
module gf4_mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] q
);
    logic [6:0] c;

    assign c[0] = a[0] & b[0];
    assign c[1] = (a[0] & b[1]) ^ (a[1] & b[0]);
    assign c[2] = (a[0] & b[2]) ^ (a[1] & b[1]) ^ (a[2] & b[0]);
    assign c[3] = (a[0] & b[3]) ^ (a[1] & b[2]) ^ (a[2] & b[1]) ^ (a[3] & b[0]);
    assign c[4] = (a[1] & b[3]) ^ (a[2] & b[2]) ^ (a[3] & b[1]);
    assign c[5] = (a[2] & b[3]) ^ (a[3] & b[2]);
    assign c[6] = a[3] & b[3];

    // x^4 = x+1, x^5 = x^2+x, x^6 = x^3+x^2
    assign q[0] = c[0] ^ c[4];
    assign q[1] = c[1] ^ c[4] ^ c[5];
    assign q[2] = c[2] ^ c[5] ^ c[6];
    assign q[3] = c[3] ^ c[6];

endmodule

// File: tb/tb_ti_gf4_mul_pipe.sv
// Bench for ti_gf4_mul_pipe: fixed vectors, random streaming against a field-arithmetic
// model, back-pressure, flush and reset sequences on REFRESH=1 and REFRESH=0 instances.
`timescale 1ns/1ps

module tb_ti_gf4_mul_pipe;
    localparam int NL = 2;
    localparam int W  = 4 * NL;
    localparam int RW = 12 * NL;
    localparam int NRAND = 1500;

    typedef struct packed {
        logic [3:0][W-1:0] x;
        logic [3:0][W-1:0] y;
        logic [RW-1:0]     r;
        logic [3:0][W-1:0] q;
        logic [3:0][W-1:0] p;
    } vec_t;

    logic          clk = 1'b0;
    logic          rstN, clr, inValid, outReady;
    logic [W-1:0]  xs [4];
    logic [W-1:0]  ys [4];
    logic [RW-1:0] rnd;
    logic          inReady1, outValid1, inReady0, outValid0;
    logic [W-1:0]  q1 [4];
    logic [W-1:0]  q0 [4];
    int            nAssert = 0;
    int            nFail = 0;

    always #5 clk = ~clk;

    ti_gf4_mul_pipe #(.N_LANES(NL), .REFRESH(1)) dut (
        .ClkxCI(clk), .RstxBI(rstN), .ClrxSI(clr),
        .InValidxSI(inValid), .InReadyxSO(inReady1),
        .XxDI0(xs[0]), .XxDI1(xs[1]), .XxDI2(xs[2]), .XxDI3(xs[3]),
        .YxDI0(ys[0]), .YxDI1(ys[1]), .YxDI2(ys[2]), .YxDI3(ys[3]),
        .RandxDI(rnd), .OutValidxSO(outValid1), .OutReadyxSI(outReady),
        .QxDO0(q1[0]), .QxDO1(q1[1]), .QxDO2(q1[2]), .QxDO3(q1[3])
    );

    ti_gf4_mul_pipe #(.N_LANES(NL), .REFRESH(0)) dutPlain (
        .ClkxCI(clk), .RstxBI(rstN), .ClrxSI(clr),
        .InValidxSI(inValid), .InReadyxSO(inReady0),
        .XxDI0(xs[0]), .XxDI1(xs[1]), .XxDI2(xs[2]), .XxDI3(xs[3]),
        .YxDI0(ys[0]), .YxDI1(ys[1]), .YxDI2(ys[2]), .YxDI3(ys[3]),
        .RandxDI(rnd), .OutValidxSO(outValid0), .OutReadyxSI(outReady),
        .QxDO0(q0[0]), .QxDO1(q0[1]), .QxDO2(q0[2]), .QxDO3(q0[3])
    );

    // Shift-and-add multiply with reduction by x^4 + x + 1.
    function automatic logic [3:0] gfMul(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] aa;
        logic [3:0] p;
        aa = {1'b0, a};
        p  = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa[3:0];
            aa = aa << 1;
            if (aa[4]) aa = aa ^ 5'h13;
        end
        return p;
    endfunction

    function automatic logic [3:0][W-1:0] termsOf(input vec_t v);
        logic [3:0][W-1:0] p;
        logic [3:0] x0, x1, x2, x3, y0, y1, y2, y3;
        p = '0;
        for (int k = 0; k < NL; k++) begin
            x0 = v.x[0][4*k +: 4]; x1 = v.x[1][4*k +: 4];
            x2 = v.x[2][4*k +: 4]; x3 = v.x[3][4*k +: 4];
            y0 = v.y[0][4*k +: 4]; y1 = v.y[1][4*k +: 4];
            y2 = v.y[2][4*k +: 4]; y3 = v.y[3][4*k +: 4];
            p[0][4*k +: 4] = gfMul(x2 ^ x3, y1 ^ y2);
            p[1][4*k +: 4] = gfMul(x0 ^ x2, y0 ^ y3);
            p[2][4*k +: 4] = gfMul(x1 ^ x3, y0 ^ y3);
            p[3][4*k +: 4] = gfMul(x0 ^ x1, y1 ^ y2);
        end
        return p;
    endfunction

    function automatic logic [3:0][W-1:0] maskOf(input logic [RW-1:0] r);
        logic [3:0][W-1:0] m;
        logic [11:0] lr;
        m = '0;
        for (int k = 0; k < NL; k++) begin
            lr = r[12*k +: 12];
            m[0][4*k +: 4] = lr[3:0];
            m[1][4*k +: 4] = lr[7:4];
            m[2][4*k +: 4] = lr[11:8];
            m[3][4*k +: 4] = lr[3:0] ^ lr[7:4] ^ lr[11:8];
        end
        return m;
    endfunction

    function automatic vec_t randVec();
        vec_t v;
        logic [31:0] t;
        v = '0;
        for (int s = 0; s < 4; s++) begin
            t = $urandom(); v.x[s] = t[W-1:0];
            t = $urandom(); v.y[s] = t[W-1:0];
        end
        t = $urandom(); v.r = t[RW-1:0];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyVec(input vec_t v);
        for (int s = 0; s < 4; s++) begin
            xs[s] = v.x[s];
            ys[s] = v.y[s];
        end
        rnd = v.r;
    endtask

    // Recombined output of each instance must equal the plain field product per lane.
    task automatic laneProdCheck(input string name, input vec_t v);
        logic [3:0] xa, ya, qa, qb;
        for (int k = 0; k < NL; k++) begin
            xa = v.x[0][4*k +: 4] ^ v.x[1][4*k +: 4] ^ v.x[2][4*k +: 4] ^ v.x[3][4*k +: 4];
            ya = v.y[0][4*k +: 4] ^ v.y[1][4*k +: 4] ^ v.y[2][4*k +: 4] ^ v.y[3][4*k +: 4];
            qa = q1[0][4*k +: 4] ^ q1[1][4*k +: 4] ^ q1[2][4*k +: 4] ^ q1[3][4*k +: 4];
            qb = q0[0][4*k +: 4] ^ q0[1][4*k +: 4] ^ q0[2][4*k +: 4] ^ q0[3][4*k +: 4];
            check({name, " refresh xor"}, qa, gfMul(xa, ya));
            check({name, " plain xor"}, qb, gfMul(xa, ya));
        end
    endtask

    initial begin
        vec_t tbl [6];
        vec_t h1, h2, cur, head, items [8];
        vec_t expQ [$];
        logic v1, v2;
        logic [RW-1:0] rPrev;
        logic [3:0][W-1:0] m, pp;
        logic [31:0] t;
        logic [W-1:0] holdQ [4];
        int idx, outCount, stall, notReadySeen;
        logic seenFirst, held, chkBubble, prevReady;

        tbl[0] = '{x: 32'h55555555, y: 32'h3A710FC4, r: 24'hABCABC, q: 32'hDDAABBCC, p: 32'h0};
        tbl[1] = '{x: 32'h00000022, y: 32'h00000082, r: 24'h0, q: 32'h00003400, p: 32'h00003400};
        tbl[2] = '{x: 32'h00000038, y: 32'h00000078, r: 24'h0, q: 32'h00009C00, p: 32'h00009C00};
        tbl[3] = '{x: 32'h0000009F, y: 32'h000000EF, r: 24'h0, q: 32'h00007A00, p: 32'h00007A00};
        tbl[4] = '{x: 32'h00000001, y: 32'h0000005B, r: 24'h0, q: 32'h00000B00, p: 32'h00000B00};
        tbl[5] = '{x: 32'h00000022, y: 32'h00000082, r: 24'h654321, q: 32'h70636641, p: 32'h00003400};

        rstN = 1'b0; clr = 1'b0; inValid = 1'b0; outReady = 1'b1;
        for (int s = 0; s < 4; s++) begin xs[s] = '0; ys[s] = '0; end
        rnd = '0;
        repeat (2) @(negedge clk);
        check("reset out valid", outValid1, 0);
        check("reset in ready", inReady1, 1);
        check("reset plain out valid", outValid0, 0);
        for (int s = 0; s < 4; s++) check("reset Q", q1[s], 0);
        rstN = 1'b1;

        // Fixed vectors, one at a time
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            applyVec(tbl[i]);
            inValid = 1'b1;
            @(negedge clk);
            inValid = 1'b0;
            @(negedge clk);
            check("table valid", outValid1, 1);
            for (int s = 0; s < 4; s++) begin
                check("table Q", q1[s], tbl[i].q[s]);
                check("table plain Q", q0[s], tbl[i].p[s]);
            end
        end
        repeat (3) @(negedge clk);

        // Random streaming with OutReadyxSI held high: item of cycle i emerges at cycle i+2,
        // remasked with the randomness presented in cycle i+1.
        v1 = 1'b0; v2 = 1'b0; h1 = '0; h2 = '0; rPrev = '0;
        for (int it = 0; it < NRAND + 2; it++) begin
            @(negedge clk);
            if (it >= 2) begin
                check("rand valid", outValid1, v2);
                if (v2) begin
                    m  = maskOf(rPrev);
                    pp = termsOf(h2);
                    for (int s = 0; s < 4; s++) begin
                        check("rand Q share", q1[s], pp[s] ^ m[s]);
                        check("rand plain share", q0[s], pp[s]);
                    end
                    laneProdCheck("rand", h2);
                end
            end
            h2 = h1; v2 = v1;
            cur = randVec();
            t = $urandom();
            if (it < NRAND) inValid = (t[1:0] != 2'b00);
            else inValid = 1'b0;
            applyVec(cur);
            h1 = cur; v1 = inValid; rPrev = cur.r;
        end
        inValid = 1'b0;
        repeat (3) @(negedge clk);

        // Back-pressure: 8 items, output stalled 5 cycles once the first result shows
        for (int i = 0; i < 8; i++) items[i] = randVec();
        idx = 0; outCount = 0; stall = 0; notReadySeen = 0;
        seenFirst = 1'b0; held = 1'b0; chkBubble = 1'b0; prevReady = 1'b1;
        for (int s = 0; s < 4; s++) holdQ[s] = '0;
        for (int cyc = 0; cyc < 100 && outCount < 8; cyc++) begin
            @(negedge clk);
            if (!seenFirst && outValid1) begin seenFirst = 1'b1; stall = 5; end
            prevReady = outReady;
            outReady = (stall == 0);
            if (stall > 0) stall--;
            if (idx < 8) begin applyVec(items[idx]); inValid = 1'b1; end
            else inValid = 1'b0;
            t = $urandom(); rnd = t[RW-1:0];
            #1;
            if (chkBubble) begin check("no bubble", outValid1, 1); chkBubble = 1'b0; end
            if (held) begin
                check("hold valid", outValid1, 1);
                for (int s = 0; s < 4; s++) check("hold Q", q1[s], holdQ[s]);
            end
            check("in ready", inReady1, (expQ.size() < 2 || outReady) ? 1 : 0);
            if (!inReady1) notReadySeen++;
            if (outReady && !prevReady) begin
                check("release accept", inReady1, 1);
                chkBubble = 1'b1;
            end
            if (outValid1 && outReady) begin
                if (expQ.size() == 0) begin
                    nAssert++; nFail++;
                    $display("FAIL bp duplicate: output with nothing in flight at %0t", $time);
                end else begin
                    head = expQ.pop_front();
                    laneProdCheck("bp order", head);
                end
                outCount++;
            end
            if (inValid && inReady1) begin expQ.push_back(items[idx]); idx++; end
            held = outValid1 && !outReady;
            for (int s = 0; s < 4; s++) holdQ[s] = q1[s];
        end
        check("bp outputs", outCount, 8);
        check("bp accepted", idx, 8);
        check("bp left over", expQ.size(), 0);
        check("bp stall seen", (notReadySeen > 0) ? 1 : 0, 1);
        inValid = 1'b0; outReady = 1'b1;
        repeat (3) @(negedge clk);

        // Flush with two items in flight, then a fresh item must come through alone
        outReady = 1'b0;
        applyVec(randVec()); inValid = 1'b1;
        @(negedge clk);
        applyVec(randVec());
        @(negedge clk);
        inValid = 1'b0; clr = 1'b1;
        #1;
        check("flush pre valid", outValid1, 1);
        check("flush in ready", inReady1, 0);
        @(negedge clk);
        clr = 1'b0;
        #1;
        check("flush valid", outValid1, 0);
        check("flush plain valid", outValid0, 0);
        check("flush ready after", inReady1, 1);
        outReady = 1'b1;
        cur = randVec();
        applyVec(cur); inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        @(negedge clk);
        check("post flush valid", outValid1, 1);
        m = maskOf(cur.r); pp = termsOf(cur);
        for (int s = 0; s < 4; s++) check("post flush Q", q1[s], pp[s] ^ m[s]);
        @(negedge clk);
        check("post flush drained", outValid1, 0);

        // Asynchronous reset while a result is waiting
        cur = randVec();
        applyVec(cur); inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0; outReady = 1'b0;
        @(negedge clk);
        check("pre reset valid", outValid1, 1);
        #2 rstN = 1'b0;
        #1;
        check("mid reset valid", outValid1, 0);
        check("mid reset ready", inReady1, 1);
        for (int s = 0; s < 4; s++) begin
            check("mid reset Q", q1[s], 0);
            check("mid reset plain Q", q0[s], 0);
        end
        @(negedge clk);
        rstN = 1'b1; outReady = 1'b1;
        repeat (2) @(negedge clk);
        check("after reset valid", outValid1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
